// File: rtl/codeout_pkg.sv
// codeout_pkg: shared FSM state type and byte-enable helper for codeout_pack
package codeout_pkg;
    typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, END} state_t;
    // Low (lanes * bytes_per_lane) bits set, saturating at 64 bytes.
    function automatic logic [63:0] be_mask(input int unsigned lanes, input int unsigned bytes_per_lane);
        int unsigned n;
        n = lanes * bytes_per_lane;
        return n >= 64 ? '1 : (64'd1 << n) - 64'd1;
    endfunction
endpackage

// File: rtl/codeout_fifo.sv
// codeout_fifo: synchronous show-ahead FIFO for packed words
//   wb_clk_i, wb_rst_n_i : clock, synchronous active-low reset
//   push, wdata          : write strobe and entry (accepted when not full, or full with a same-cycle pop)
//   pop, rdata           : read strobe and head entry (valid whenever not empty)
//   full, empty, count   : occupancy status
module codeout_fifo #(
    parameter int W = 73,
    parameter int DEPTH = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata = mem[rp];
    always_ff @(posedge wb_clk_i)
        if (do_push) mem[wp] <= wdata;
    always_ff @(posedge wb_clk_i)
        if (!wb_rst_n_i) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(do_push);
            rp <= rp + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/codeout_pack.sv
// codeout_pack: selects a symbol source, packs symbols into words, buffers and drains them
//   wb_clk_i, wb_rst_n_i          : clock, synchronous active-low reset
//   ch_sel, src_data/valid/done   : source select and per-channel symbol interface
//   src_ready                     : selected source may present a symbol
//   m_enable, m_full              : destination enable and backpressure
//   m_dst, m_dst_be, m_dst_last   : registered destination word, byte enables, last flag
//   m_dst_putn, m_endn            : active-low word strobe and end-of-stream pulse
module codeout_pack
    import codeout_pkg::*;
#(
    parameter int IN_W = 16,
    parameter int OUT_W = 64,
    parameter int NCH = 2,
    parameter logic [NCH-1:0] SWAP_MASK = 2'b01,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic [$clog2(NCH)-1:0]   ch_sel,
    input  logic [NCH*IN_W-1:0]      src_data,
    input  logic [NCH-1:0]           src_valid,
    input  logic [NCH-1:0]           src_done,
    output logic                     src_ready,
    input  logic                     m_enable,
    input  logic                     m_full,
    output logic [OUT_W-1:0]         m_dst,
    output logic [OUT_W/8-1:0]       m_dst_be,
    output logic                     m_dst_putn,
    output logic                     m_dst_last,
    output logic                     m_endn
);
    localparam int R = OUT_W / IN_W;
    localparam int CW = $clog2(R);
    localparam int BW = OUT_W / 8;
    localparam int BPL = IN_W / 8;
    localparam int EW = OUT_W + BW + 1;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [OUT_W-1:0] word, word_nxt;
    logic wrap_full;
    logic [IN_W-1:0] sym_raw, sym_swap, sym;
    logic active, last_lane, beat, done_hit, push_full, flush_push, push, pop;
    logic [BW-1:0] be_part;
    logic [EW-1:0] push_data, head;
    logic fifo_full, fifo_empty;
    logic [FCW-1:0] fifo_count;
    assign sym_raw = src_data[ch_sel*IN_W +: IN_W];
    for (genvar b = 0; b < BPL; b++) begin : g_swap
        assign sym_swap[b*8 +: 8] = sym_raw[(BPL-1-b)*8 +: 8];
    end
    assign sym = SWAP_MASK[ch_sel] ? sym_swap : sym_raw;
    assign active = state == IDLE || state == RUN;
    assign last_lane = cnt == CW'(R-1);
    assign src_ready = active && !(fifo_full && last_lane);
    assign beat = src_valid[ch_sel] && src_ready;
    assign done_hit = active && src_done[ch_sel];
    // A word completed in the same cycle as done is held back so the flush marks it last.
    assign push_full = beat && last_lane && !done_hit;
    assign flush_push = state == FLUSH && fifo_count != FCW'(FIFO_DEPTH);
    assign push = push_full || flush_push;
    assign be_part = wrap_full ? '1 : BW'(be_mask(32'(cnt), 32'(BPL)));
    assign push_data = push_full ? {1'b0, {BW{1'b1}}, word_nxt} : {1'b1, be_part, word};
    assign pop = m_enable && !m_full && !fifo_empty;
    always_comb begin
        word_nxt = word;
        if (beat) word_nxt[cnt*IN_W +: IN_W] = sym;
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = done_hit ? FLUSH : beat ? RUN : IDLE;
            RUN:   state_nxt = done_hit ? FLUSH : RUN;
            FLUSH: state_nxt = flush_push ? DRAIN : FLUSH;
            // The final word is on the outputs this cycle.
            DRAIN: state_nxt = (!m_dst_putn && m_dst_last) ? END : DRAIN;
            END:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i)
        if (!wb_rst_n_i) begin
            state <= IDLE;
            cnt <= '0;
            word <= '0;
            wrap_full <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush_push) begin
                cnt <= '0;
                word <= '0;
                wrap_full <= 1'b0;
            end else if (beat) begin
                cnt <= cnt + CW'(1);
                word <= push_full ? '0 : word_nxt;
                wrap_full <= last_lane && done_hit;
            end
        end
    always_ff @(posedge wb_clk_i)
        if (!wb_rst_n_i) begin
            m_dst <= '0;
            m_dst_be <= '0;
            m_dst_last <= 1'b0;
            m_dst_putn <= 1'b1;
            m_endn <= 1'b1;
        end else begin
            m_dst_putn <= !pop;
            m_endn <= state != END;
            if (pop) {m_dst_last, m_dst_be, m_dst} <= head;
        end
    codeout_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n_i(wb_rst_n_i),
        .push      (push),
        .wdata     (push_data),
        .pop       (pop),
        .rdata     (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );
endmodule
